// File: rtl/cmd_pulse_reg_16.sv
// Host register block for 16-bit command/status registers, with a feedback TTL pulse-train generator.
// Writes to FB_CMD start or abort a train; STATUS reports busy and the number of completed pulses.
module cmd_pulse_reg_16 #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       din,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              thr_en,
  output logic              mua_en,
  output logic              ttl_out,
  output logic              fb_busy,
  output logic              fb_done
);

  localparam int DATA_W = 16;
  localparam int NREG   = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_WIDTH  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_GAP    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CMD    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(5);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [NREG];
  logic [15:0]       width_q, width_nxt;
  logic [15:0]       gap_q, gap_nxt;
  logic [15:0]       phase_q, phase_nxt;
  logic [15:0]       rem_q, rem_nxt;
  logic [14:0]       pd_q, pd_nxt;
  logic              done_nxt;
  logic              cmd_wr, start, abort;
  logic [DATA_W-1:0] rd_data;

  // Zero-length phases would stall the counters, so they are stretched to one cycle.
  function automatic logic [15:0] min_one(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  function automatic logic [14:0] sat_inc(input logic [14:0] v);
    return (v == 15'h7FFF) ? v : v + 15'd1;
  endfunction

  assign cmd_wr  = we && (addr == A_CMD);
  assign abort   = cmd_wr && din[1];
  assign start   = cmd_wr && din[0] && !din[1] && (state == IDLE) && (regs[A_COUNT] != 16'd0);

  assign thr_en  = regs[A_CTRL][0];
  assign mua_en  = regs[A_CTRL][1];
  assign ttl_out = (state == HIGH);
  assign fb_busy = (state != IDLE);

  always_comb begin
    case (addr)
      A_CMD:    rd_data = 16'h0000;
      A_STATUS: rd_data = {fb_busy, pd_q};
      default:  rd_data = regs[addr];
    endcase
  end

  always_comb begin
    state_nxt = state;
    width_nxt = width_q;
    gap_nxt   = gap_q;
    phase_nxt = phase_q;
    rem_nxt   = rem_q;
    pd_nxt    = pd_q;
    done_nxt  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            width_nxt = min_one(regs[A_WIDTH]);
            gap_nxt   = min_one(regs[A_GAP]);
            rem_nxt   = regs[A_COUNT];
            phase_nxt = min_one(regs[A_WIDTH]) - 16'd1;
            pd_nxt    = 15'd0;
            state_nxt = HIGH;
          end
        end
        HIGH: begin
          if (phase_q == 16'd0) begin
            pd_nxt = sat_inc(pd_q);
            if (rem_q == 16'd1) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              rem_nxt   = rem_q - 16'd1;
              phase_nxt = gap_q - 16'd1;
              state_nxt = GAP;
            end
          end else begin
            phase_nxt = phase_q - 16'd1;
          end
        end
        GAP: begin
          if (phase_q == 16'd0) begin
            phase_nxt = width_q - 16'd1;
            state_nxt = HIGH;
          end else begin
            phase_nxt = phase_q - 16'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Register file, read port and train state all update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      width_q <= 16'd0;
      gap_q   <= 16'd0;
      phase_q <= 16'd0;
      rem_q   <= 16'd0;
      pd_q    <= 15'd0;
      fb_done <= 1'b0;
      dout    <= 16'h0000;
      for (int i = 0; i < NREG; i++) regs[i] <= 16'h0000;
    end else begin
      state   <= state_nxt;
      width_q <= width_nxt;
      gap_q   <= gap_nxt;
      phase_q <= phase_nxt;
      rem_q   <= rem_nxt;
      pd_q    <= pd_nxt;
      fb_done <= done_nxt;
      if (re) dout <= rd_data;
      if (we && (addr != A_CMD) && (addr != A_STATUS)) regs[addr] <= din;
    end
  end

endmodule
